// File: rtl/bios_loader.sv
// bios_loader: copies WORDS words from the BIOS ROM into RAM at DEST_BASE,
// holding the CPU in reset until the copy has finished.
// Optional feature: define BIOS_LOADER_CHECKSUM_EN to build a 32-bit
// wrap-around sum of every accepted write; otherwise checksum is tied to 0.
module bios_loader #(
  parameter logic [31:0] DEST_BASE = 32'h0000_0000,
  parameter int unsigned WORDS     = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  rom_addr,
  input  logic [47:0] rom_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        cpu_rst,
  output logic [31:0] checksum
);

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cpu_rst_q, cpu_rst_d;

  // The upper ROM bits carry no payload.
  logic unused_rom_hi;
  assign unused_rom_hi = ^rom_data[47:32];

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rom_addr_q  <= '0;
      mem_addr_q  <= DEST_BASE;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rom_addr_q  <= rom_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // registered alongside it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rom_addr_d  = rom_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d      = '0;
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        mem_wdata_d = rom_data[DATA_W-1:0];
        mem_addr_d  = DEST_BASE + ADDR_W'({idx_q, 2'b00});
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            rom_addr_d = idx_q + IDX_W'(1);
            state_d    = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_we_d  = (state_d == ST_WRITE);
    busy_d    = (state_d == ST_FETCH) || (state_d == ST_LATCH) ||
                (state_d == ST_WRITE);
    done_d    = (state_d == ST_DONE);
    cpu_rst_d = (state_d != ST_DONE);
  end

  assign rom_addr  = rom_addr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_rst   = cpu_rst_q;

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Accumulate each accepted write; a new start clears the sum.
  always_comb begin
    sum_d = sum_q;
    if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
      sum_d = '0;
    end else if ((state_q == ST_WRITE) && mem_ready) begin
      sum_d = sum_q + mem_wdata_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/bios_loader.md
BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 The block SHALL have parameter DEST_BASE, default 32'h0000_0000: byte address of the first RAM word written.
REQ-002 The block SHALL have parameter WORDS, default 128: number of ROM words copied, legal range 1..128.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a BIOS copy.
REQ-006 The block SHALL have port rom_addr, output, 7 bits: word address to the BIOS ROM.
REQ-007 The block SHALL have port rom_data, input, 48 bits: ROM read data; valid one cycle after rom_addr is sampled; bits [47:32] carry no payload.
REQ-008 The block SHALL have port mem_addr, output, 32 bits: RAM byte address.
REQ-009 The block SHALL have port mem_wdata, output, 32 bits: RAM write data.
REQ-010 The block SHALL have port mem_we, output, 1 bit: RAM write request.
REQ-011 The block SHALL have port mem_ready, input, 1 bit: RAM accepts the write on a cycle where mem_we and mem_ready are both high.
REQ-012 The block SHALL have port busy, output, 1 bit: copy in progress.
REQ-013 The block SHALL have port done, output, 1 bit: copy complete.
REQ-014 The block SHALL have port cpu_rst, output, 1 bit: holds the CPU in reset until the copy completes.
REQ-015 The block SHALL have port checksum, output, 32 bits: running sum of the copied words (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, LATCH, WRITE and DONE.
REQ-017 In IDLE and DONE, start=1 SHALL clear idx and the checksum and move to FETCH; start=0 SHALL hold the current state.
REQ-018 In FETCH, rom_addr SHALL equal idx, and the next state SHALL be LATCH.
REQ-019 In LATCH, rom_data[31:0] SHALL be captured into the mem_wdata register, and the next state SHALL be WRITE.
REQ-020 In WRITE, mem_we SHALL be 1 and mem_addr SHALL equal DEST_BASE + 4*idx (mod 2^32).
REQ-021 In WRITE with mem_ready=0, all outputs SHALL hold and the state SHALL remain WRITE.
REQ-022 In WRITE with mem_ready=1, idx SHALL increment; if idx was WORDS-1 the next state SHALL be DONE, otherwise FETCH.
REQ-023 mem_we SHALL be 0 in every state other than WRITE.
REQ-024 mem_addr and mem_wdata SHALL be stable while mem_we=1.
REQ-025 rom_data[47:32] SHALL be ignored.
REQ-026 busy SHALL be 1 exactly in FETCH, LATCH and WRITE.
REQ-027 done SHALL be 1 exactly in DONE.
REQ-028 cpu_rst SHALL be 0 only in DONE.
REQ-029 start asserted while busy=1 SHALL be ignored.
REQ-030 A start in DONE SHALL re-copy, with cpu_rst returning to 1 the cycle after start is sampled.
REQ-031 With mem_ready held at 1, start sampled at edge E0 SHALL give done=1 from edge E0 + 3*WORDS onward; each word takes 3 cycles.
REQ-032 idx SHALL be 7 bits plus a terminal compare; rom_addr SHALL never exceed WORDS-1.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, idx=0, checksum=0, mem_wdata=0, mem_we=0, busy=0, done=0, cpu_rst=1, rom_addr=0, and mem_addr=DEST_BASE.
REQ-034 rst asserted mid-copy SHALL abort the copy immediately, including in WRITE with mem_ready=0, with no further writes.
REQ-035 After rst deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-036 With BIOS_LOADER_CHECKSUM_EN defined, each accepted write SHALL add mem_wdata to checksum (32-bit, wrap-around), and checksum SHALL be valid when done=1.
REQ-037 Without BIOS_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator SHALL be built.

Verification
REQ-038 Scenario: ROM mem[i]=i+1, WORDS=128, mem_ready=1, start pulse -> 128 writes, addr 0x0..0x1FC, data 1..128, done at start+384 cycles, checksum=0x2040 (macro on) or 0 (macro off).
REQ-039 Scenario: rom_data[47:32]=16'hFFFF on every word -> mem_wdata equals the low 32 bits only.
REQ-040 Scenario: DEST_BASE=0x1000, WORDS=4, mem_ready low for 5 cycles in the second WRITE -> mem_we held high with addr 0x1004 and data stable; done at start+17 cycles.
REQ-041 Scenario: start re-pulsed while busy -> no restart, write count still WORDS; start in DONE -> cpu_rst=1 next cycle, full copy repeats.
REQ-042 Scenario: rst asserted during WRITE of word 10 -> mem_we drops without waiting for a clock edge, cpu_rst=1, no further writes until a new start.
REQ-043 Scenario: DEST_BASE=0xFFFF_FFFC, WORDS=2 -> addresses 0xFFFF_FFFC then 0x0000_0000.
